icache_2way: RTL and testbench
==============================

Name: icache_2way

Overview:
- Second-generation instruction cache between the IF stage and the memory controller.
- Word-granular storage (32-bit entries), parametrised set count and associativity (1 or 2 ways), true LRU for 2 ways.
- Serves 16-bit-aligned fetches, including RVC and 32-bit instructions that straddle two words.
- Owns its own miss FSM: requests missing words from the memory controller instead of relying on an external writer.

Parameters:
- INDEX_BIT, 6, log2 of set count; SETS = 2^INDEX_BIT.
- ASSOC, 2, ways per set; legal values 1 or 2.
- TAG_BIT, 32-INDEX_BIT-2, derived tag width; do not override.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; synchronous, active-high
- rdy_in  in  1  global ready; low = freeze all state
- rob_clear_up  in  1  pipeline flush (mispredict)
- inv_all  in  1  invalidate every entry (fence.i)
- fetch_valid  in  1  IF requests instruction at fetch_addr
- fetch_addr  in  32  halfword-aligned PC; bit0 = 0
- hit  out  1  inst_out valid this cycle
- inst_out  out  32  instruction; upper half don't-care when RVC
- is_i_out  out  1  inst_out[1:0]==2'b11 (32-bit instruction)
- mem_req  out  1  word read request to memory controller
- mem_addr  out  32  word-aligned request address
- mem_done  in  1  one-cycle pulse; mem_data valid
- mem_data  in  32  returned word

Behaviour:
- Address split: word address W = addr[31:2], index = addr[INDEX_BIT+1:2], tag = addr[31:INDEX_BIT+2].
- Lookup is combinational on every cycle. It reads word W0 = fetch_addr[31:2].
  - If fetch_addr[1]=1, it also reads W1 = W0+1 (wraps index; tag increments on carry).
- Low halfword:
  - lo = fetch_addr[1] ? W0[31:16] : W0[15:0]
  - needs_hi = fetch_addr[1] && lo[1:0]==2'b11
  - hi = W1[15:0]
- Output composition:
  - inst_out = needs_hi ? {hi, lo} : (fetch_addr[1] ? {16'h0, lo} : W0 data)
  - hit = fetch_valid && state==IDLE && W0 hit && (!needs_hi || W1 hit) && !rob_clear_up
  - inst_out = 0 when hit=0
- FSM states: IDLE, REQ.
  - IDLE → REQ when fetch_valid && !hit && !rob_clear_up.
    - Latch miss address: W0 if W0 missed, otherwise W1.
    - mem_req = 1 and mem_addr = {missW, 2'b00} from the next cycle.
  - REQ: hold mem_req and mem_addr stable until mem_done.
    - On the mem_done edge: install mem_data into the victim way, set valid, write tag, drop mem_req, go to IDLE.
    - The retried lookup hits no earlier than 1 cycle after mem_done.
    - A straddling double miss takes two sequential refills.
- Victim selection: invalid way first (way0 before way1); otherwise the LRU way.
- LRU update (one bit per set):
  - A hit on W0 (and on W1 when used) marks that way MRU.
  - A fill marks the filled way MRU.
  - ASSOC=1: no LRU storage; way0 is always the victim.
- rob_clear_up:
  - In IDLE: suppresses hit for that cycle.
  - In REQ: the request is not aborted, because the memory controller cannot cancel. The refill completes and is installed, since the data is architecturally correct. IF must re-present its new PC.
- inv_all:
  - Clears every valid bit at the edge. Tags, data and LRU are untouched.
  - If asserted in REQ, the in-flight word is still written, but its valid bit stays 0. Achieve this with a per-FSM "poison" flag that is cleared on return to IDLE.
- rdy_in=0: no state changes, mem_done ignored. The controller is contractually frozen too.
- Reset:
  - All valid bits and LRU bits = 0, state = IDLE, mem_req = 0, mem_addr = 0, poison = 0.
  - hit = 0 and inst_out = 0 follow from the invalid arrays.
  - Reset during REQ abandons the refill; the controller is reset in the same cycle.
- Simultaneous mem_done and inv_all: fill occurs with valid=0.

Optional Feature:
- Macro ICACHE_STAT_EN.
- Defined: adds outputs stat_hits (32) and stat_misses (32).
  - stat_hits: +1 per cycle with hit=1.
  - stat_misses: +1 per IDLE→REQ transition.
  - Both saturate at 32'hFFFFFFFF, reset to 0, frozen when rdy_in=0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package/Const.v holds: ICACHE_INDEX_BIT default, ICACHE_ASSOC default, FSM state encodings (IDLE=1'b0, REQ=1'b1).
- One natural sub-module: icache_way, one storage way. It provides valid/tag/data arrays, two combinational read ports (W0, W1), one write port, and a clear-all input.
  - Instantiated ASSOC times.
- The top level holds the LRU, the FSM and the halfword stitch.

Test Plan:
- Cold fetch 0x0000_1000 (word 0x00A00093) → mem_req/mem_addr=0x1000 next cycle; mem_done → hit=1, inst_out=0x00A00093, is_i_out=1 the cycle after.
- Straddle: words 0x1000=0x0001_4505, 0x1004=0xXXXX_0093 both cold, fetch 0x1002 (lo=0x0001) → RVC, needs_hi=0, one refill only, inst_out=0x0000_0001, is_i_out=0.
  - Repeat with lo=0x0093 → two refills (0x1000 then 0x1004), then inst_out={0x1004[15:0], 0x0093}.
- 2-way conflict: fill 0x1000, 0x1000+4·SETS, touch 0x1000, then miss 0x1000+8·SETS → evicts the second line; 0x1000 still hits.
- rob_clear_up during REQ → refill still installed; re-fetch of the same address hits with no mem_req.
- inv_all mid-REQ → after mem_done the same address misses again (new mem_req); with ICACHE_STAT_EN stat_misses=2.
- rdy_in low for 5 cycles across mem_done pulse → no fill, state stays REQ, mem_req held.

Source files
------------

// File: rtl/icache_2way_pkg.sv
// Shared constants and types for the two-way instruction cache.
// Default geometry and the miss-FSM state encoding live here.
package icache_2way_pkg;

    localparam int ICACHE_INDEX_BIT = 6;
    localparam int ICACHE_ASSOC     = 2;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Pick one halfword out of a cached word.
    function automatic logic [15:0] pick_half(input logic [31:0] word, input logic upper);
        return upper ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/icache_way.sv
// One storage way: valid/tag/data arrays with two combinational lookup
// ports, a single fill port and a clear-all of the valid bits.
module icache_way #(
    parameter int INDEX_BIT = 6,
    parameter int TAG_BIT   = 32 - INDEX_BIT - 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 en,
    input  logic                 clear_all,
    input  logic [INDEX_BIT-1:0] rd0_index,
    input  logic [TAG_BIT-1:0]   rd0_tag,
    output logic                 rd0_hit,
    output logic [31:0]          rd0_data,
    input  logic [INDEX_BIT-1:0] rd1_index,
    input  logic [TAG_BIT-1:0]   rd1_tag,
    output logic                 rd1_hit,
    output logic [31:0]          rd1_data,
    input  logic                 wr_en,
    input  logic [INDEX_BIT-1:0] wr_index,
    input  logic [TAG_BIT-1:0]   wr_tag,
    input  logic [31:0]          wr_data,
    input  logic                 wr_valid,
    output logic                 wr_slot_valid
);

    localparam int SETS = 1 << INDEX_BIT;

    logic [SETS-1:0]    valid_reg;
    logic [TAG_BIT-1:0] tag_mem  [SETS];
    logic [31:0]        data_mem [SETS];

    // A fill in the same cycle as clear_all carries wr_valid=0 from the top.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_reg <= '0;
        end else if (en) begin
            if (clear_all)
                valid_reg <= '0;
            if (wr_en)
                valid_reg[wr_index] <= wr_valid;
        end
    end

    always_ff @(posedge clk_in) begin
        if (en && wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd0_hit       = valid_reg[rd0_index] && (tag_mem[rd0_index] == rd0_tag);
    assign rd0_data      = data_mem[rd0_index];
    assign rd1_hit       = valid_reg[rd1_index] && (tag_mem[rd1_index] == rd1_tag);
    assign rd1_data      = data_mem[rd1_index];
    assign wr_slot_valid = valid_reg[wr_index];

endmodule

// File: rtl/icache_2way.sv
// Instruction cache with halfword fetch stitching, LRU replacement and its own
// miss FSM. Define ICACHE_STAT_EN to add saturating hit/miss counters.
module icache_2way
    import icache_2way_pkg::*;
#(
    parameter int INDEX_BIT = ICACHE_INDEX_BIT,
    parameter int ASSOC     = ICACHE_ASSOC,
    parameter int TAG_BIT   = 32 - INDEX_BIT - 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
    input  logic        inv_all,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    output logic        hit,
    output logic [31:0] inst_out,
    output logic        is_i_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);

    localparam int SETS = 1 << INDEX_BIT;

    logic [29:0]          w0, w1;
    logic [INDEX_BIT-1:0] idx0, idx1, miss_index;
    logic [TAG_BIT-1:0]   tag0, tag1, miss_tag;
    logic [ASSOC-1:0]     hit0_way, hit1_way, slot_valid;
    logic [31:0]          data0_way [ASSOC];
    logic [31:0]          data1_way [ASSOC];
    logic                 w0_hit, w1_hit, w0_way, w1_way;
    logic [31:0]          w0_data, w1_data;
    logic [15:0]          lo;
    logic                 needs_hi;
    logic                 victim, fill, fill_valid;
    logic                 unused_addr_bit;

    state_t      state_reg, state_next;
    logic [29:0] miss_w_reg, miss_w_next;
    logic        poison_reg, poison_next;

    // W1 is the following word; the carry out of the index bumps the tag.
    assign w0         = fetch_addr[31:2];
    assign w1         = w0 + 30'd1;
    assign idx0       = w0[INDEX_BIT-1:0];
    assign tag0       = w0[29:INDEX_BIT];
    assign idx1       = w1[INDEX_BIT-1:0];
    assign tag1       = w1[29:INDEX_BIT];
    assign miss_index = miss_w_reg[INDEX_BIT-1:0];
    assign miss_tag   = miss_w_reg[29:INDEX_BIT];
    assign unused_addr_bit = fetch_addr[0];

    assign fill       = (state_reg == REQ) && mem_done && rdy_in;
    assign fill_valid = !(poison_reg || inv_all);

    generate
        for (genvar gi = 0; gi < ASSOC; gi++) begin : g_way
            icache_way #(
                .INDEX_BIT(INDEX_BIT),
                .TAG_BIT  (TAG_BIT)
            ) u_way (
                .clk_in       (clk_in),
                .rst_in       (rst_in),
                .en           (rdy_in),
                .clear_all    (inv_all),
                .rd0_index    (idx0),
                .rd0_tag      (tag0),
                .rd0_hit      (hit0_way[gi]),
                .rd0_data     (data0_way[gi]),
                .rd1_index    (idx1),
                .rd1_tag      (tag1),
                .rd1_hit      (hit1_way[gi]),
                .rd1_data     (data1_way[gi]),
                .wr_en        (fill && (int'(victim) == gi)),
                .wr_index     (miss_index),
                .wr_tag       (miss_tag),
                .wr_data      (mem_data),
                .wr_valid     (fill_valid),
                .wr_slot_valid(slot_valid[gi])
            );
        end
    endgenerate

    always_comb begin
        w0_hit  = 1'b0;
        w0_data = '0;
        w0_way  = 1'b0;
        w1_hit  = 1'b0;
        w1_data = '0;
        w1_way  = 1'b0;
        for (int i = 0; i < ASSOC; i++) begin
            if (hit0_way[i]) begin
                w0_hit  = 1'b1;
                w0_data = data0_way[i];
                w0_way  = 1'(i);
            end
            if (hit1_way[i]) begin
                w1_hit  = 1'b1;
                w1_data = data1_way[i];
                w1_way  = 1'(i);
            end
        end
    end

    assign lo       = pick_half(w0_data, fetch_addr[1]);
    assign needs_hi = fetch_addr[1] && (lo[1:0] == 2'b11);
    assign hit      = fetch_valid && (state_reg == IDLE) && w0_hit &&
                      (!needs_hi || w1_hit) && !rob_clear_up;

    always_comb begin
        inst_out = '0;
        if (hit) begin
            if (needs_hi)
                inst_out = {w1_data[15:0], lo};
            else if (fetch_addr[1])
                inst_out = {16'h0000, lo};
            else
                inst_out = w0_data;
        end
    end

    assign is_i_out = (inst_out[1:0] == 2'b11);
    assign mem_req  = (state_reg == REQ);
    assign mem_addr = {miss_w_reg, 2'b00};

    // A refill is never aborted: the controller cannot cancel it.
    always_comb begin
        state_next  = state_reg;
        miss_w_next = miss_w_reg;
        poison_next = poison_reg;
        case (state_reg)
            IDLE: begin
                if (fetch_valid && !hit && !rob_clear_up) begin
                    state_next  = REQ;
                    miss_w_next = w0_hit ? w1 : w0;
                    poison_next = 1'b0;
                end
            end
            REQ: begin
                if (inv_all)
                    poison_next = 1'b1;
                if (mem_done) begin
                    state_next  = IDLE;
                    poison_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg  <= IDLE;
            miss_w_reg <= '0;
            poison_reg <= 1'b0;
        end else if (rdy_in) begin
            state_reg  <= state_next;
            miss_w_reg <= miss_w_next;
            poison_reg <= poison_next;
        end
    end

    generate
        if (ASSOC == 2) begin : g_lru
            // Each bit names the least recently used way of its set.
            logic [SETS-1:0] lru_reg;

            assign victim = !slot_valid[0] ? 1'b0 :
                            !slot_valid[1] ? 1'b1 : lru_reg[miss_index];

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    lru_reg <= '0;
                end else if (rdy_in) begin
                    if (fill) begin
                        lru_reg[miss_index] <= ~victim;
                    end else if (hit) begin
                        lru_reg[idx0] <= ~w0_way;
                        if (needs_hi)
                            lru_reg[idx1] <= ~w1_way;
                    end
                end
            end
        end else begin : g_direct
            logic unused_lru_inputs;
            assign unused_lru_inputs = &{1'b0, slot_valid, w0_way, w1_way};
            assign victim = 1'b0;
        end
    endgenerate

`ifdef ICACHE_STAT_EN
    logic [31:0] stat_hits_reg, stat_misses_reg;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stat_hits_reg   <= '0;
            stat_misses_reg <= '0;
        end else if (rdy_in) begin
            if (hit && (stat_hits_reg != 32'hFFFF_FFFF))
                stat_hits_reg <= stat_hits_reg + 32'd1;
            if ((state_reg == IDLE) && (state_next == REQ) && (stat_misses_reg != 32'hFFFF_FFFF))
                stat_misses_reg <= stat_misses_reg + 32'd1;
        end
    end

    assign stat_hits   = stat_hits_reg;
    assign stat_misses = stat_misses_reg;
`endif

endmodule

// File: tb/tb_icache_2way.sv
// Scoreboard bench for icache_2way: the driver queues expected instructions and
// refill addresses, a negedge monitor pops and compares as the DUT produces them.
module tb_icache_2way;

    localparam int M_NORMAL = 0;
    localparam int M_ROB    = 1;
    localparam int M_INV    = 2;
    localparam int M_STALL  = 3;

    typedef struct {
        logic [31:0] inst;
        logic        is_i;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear_up, inv_all, fetch_valid;
    logic [31:0] fetch_addr;
    logic        hit, is_i_out, mem_req, mem_done;
    logic [31:0] inst_out, mem_addr, mem_data;
`ifdef ICACHE_STAT_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] mem_words [logic [31:0]];

    int          vectors = 0;
    int          miscompares = 0;
    int          timeouts = 0;
    int          hit_count = 0;
    logic        chk_reset = 1'b0, stall_chk = 1'b0, end_chk = 1'b0, end_done = 1'b0;
    logic        req_prev = 1'b0;
    logic [31:0] stall_addr = '0;

    icache_2way dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .rob_clear_up(rob_clear_up),
        .inv_all     (inv_all),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .hit         (hit),
        .inst_out    (inst_out),
        .is_i_out    (is_i_out),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_done    (mem_done),
        .mem_data    (mem_data)
`ifdef ICACHE_STAT_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (chk_reset) begin
                check("reset_hit", {31'd0, hit}, 32'd0);
                check("reset_inst", inst_out, 32'd0);
                check("reset_mem_req", {31'd0, mem_req}, 32'd0);
                check("reset_mem_addr", mem_addr, 32'd0);
            end
            if (stall_chk) begin
                check("stall_mem_req", {31'd0, mem_req}, 32'd1);
                check("stall_mem_addr", mem_addr, stall_addr);
                check("stall_hit", {31'd0, hit}, 32'd0);
            end
            if (hit) begin
                if (exp_q.size() == 0) begin
                    check("hit_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    hit_count++;
                    $display("hit %0d: addr=%h inst=%h is_i=%0d (want %h/%0d)",
                             hit_count, fetch_addr, inst_out, is_i_out, e.inst, e.is_i);
                    check("inst_out", inst_out, e.inst);
                    check("is_i_out", {31'd0, is_i_out}, {31'd0, e.is_i});
                end
            end
            if (mem_req && !req_prev) begin
                if (addr_q.size() == 0) begin
                    check("req_expected", 32'(addr_q.size()), 32'd1);
                end else begin
                    logic [31:0] ea;
                    ea = addr_q.pop_front();
                    $display("mem_req: addr=%h (want %h)", mem_addr, ea);
                    check("mem_addr", mem_addr, ea);
                end
            end
            req_prev = mem_req;
            if (end_chk && !end_done) begin
                check("exp_q_drained", 32'(exp_q.size()), 32'd0);
                check("addr_q_drained", 32'(addr_q.size()), 32'd0);
                check("fetch_timeouts", 32'(timeouts), 32'd0);
                end_done = 1'b1;
            end
        end
    end

    task automatic expect_inst(input logic [31:0] inst, input logic is_i);
        exp_t e;
        e.inst = inst;
        e.is_i = is_i;
        exp_q.push_back(e);
    endtask

    task automatic pulse_done();
        mem_data = mem_words.exists(mem_addr) ? mem_words[mem_addr] : 32'hDEAD_BEEF;
        mem_done = 1'b1;
        @(posedge clk_in); #1;
        mem_done = 1'b0;
    endtask

    // Present one fetch and act as the memory controller until it hits.
    task automatic do_fetch(input logic [31:0] a, input int mode);
        bit done = 1'b0;
        bit first = 1'b1;
        fetch_addr  = a;
        fetch_valid = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk_in);
            if (hit) begin
                done = 1'b1;
            end else if (mem_req) begin
                @(posedge clk_in); #1;
                if (first && mode == M_ROB) begin
                    rob_clear_up = 1'b1;
                    fetch_valid  = 1'b0;
                    @(posedge clk_in); #1;
                    pulse_done();
                    rob_clear_up = 1'b0;
                    done = 1'b1;
                end else if (first && mode == M_INV) begin
                    inv_all = 1'b1;
                    @(posedge clk_in); #1;
                    inv_all = 1'b0;
                    pulse_done();
                end else if (first && mode == M_STALL) begin
                    rdy_in     = 1'b0;
                    stall_addr = {a[31:2], 2'b00};
                    stall_chk  = 1'b1;
                    pulse_done();
                    repeat (4) @(posedge clk_in);
                    #1;
                    stall_chk = 1'b0;
                    rdy_in    = 1'b1;
                end else begin
                    pulse_done();
                end
                first = 1'b0;
            end
        end
        if (!done) begin
            timeouts++;
            $display("fetch %h: no hit within cycle budget", a);
        end
        @(posedge clk_in); #1;
        fetch_valid = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        rob_clear_up = 1'b0;
        inv_all = 1'b0;
        fetch_valid = 1'b0;
        fetch_addr = '0;
        mem_done = 1'b0;
        mem_data = '0;

        mem_words[32'h1000] = 32'h00A0_0093;
        mem_words[32'h1010] = 32'h0001_4505;
        mem_words[32'h1014] = 32'hABCD_0093;
        mem_words[32'h1020] = 32'h0093_4505;
        mem_words[32'h1024] = 32'h1234_5678;
        mem_words[32'h1100] = 32'h4440_0413;
        mem_words[32'h1200] = 32'h5550_0513;
        mem_words[32'h10FC] = 32'h00B3_0000;
        mem_words[32'h1040] = 32'h0640_0613;
        mem_words[32'h1050] = 32'h0C80_0693;
        mem_words[32'h1060] = 32'h12C0_0713;

        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        chk_reset = 1'b1;
        @(posedge clk_in); #1;
        chk_reset = 1'b0;

        // Cold aligned 32-bit fetch.
        addr_q.push_back(32'h1000);
        expect_inst(32'h00A0_0093, 1'b1);
        do_fetch(32'h1000, M_NORMAL);

        // Upper halfword is RVC: one refill, W1 not needed.
        addr_q.push_back(32'h1010);
        expect_inst(32'h0000_0001, 1'b0);
        do_fetch(32'h1012, M_NORMAL);
        expect_inst(32'h0001_4505, 1'b0);
        do_fetch(32'h1010, M_NORMAL);

        // Straddling 32-bit instruction: two sequential refills.
        addr_q.push_back(32'h1020);
        addr_q.push_back(32'h1024);
        expect_inst(32'h5678_0093, 1'b1);
        do_fetch(32'h1022, M_NORMAL);

        // Set 0 conflict: 0x1100 fills way1, 0x1000 touched, 0x1200 evicts 0x1100.
        addr_q.push_back(32'h1100);
        expect_inst(32'h4440_0413, 1'b1);
        do_fetch(32'h1100, M_NORMAL);
        expect_inst(32'h00A0_0093, 1'b1);
        do_fetch(32'h1000, M_NORMAL);
        addr_q.push_back(32'h1200);
        expect_inst(32'h5550_0513, 1'b1);
        do_fetch(32'h1200, M_NORMAL);
        expect_inst(32'h00A0_0093, 1'b1);
        do_fetch(32'h1000, M_NORMAL);
        addr_q.push_back(32'h1100);
        expect_inst(32'h4440_0413, 1'b1);
        do_fetch(32'h1100, M_NORMAL);

        // Straddle across the last set: W1 wraps to set 0 with tag+1.
        addr_q.push_back(32'h10FC);
        expect_inst(32'h0413_00B3, 1'b1);
        do_fetch(32'h10FE, M_NORMAL);

        // Flush during REQ: refill still installed, re-fetch hits without a request.
        addr_q.push_back(32'h1040);
        do_fetch(32'h1040, M_ROB);
        expect_inst(32'h0640_0613, 1'b1);
        do_fetch(32'h1040, M_NORMAL);

        // rdy_in low for 5 cycles across a mem_done pulse.
        addr_q.push_back(32'h1060);
        expect_inst(32'h12C0_0713, 1'b1);
        do_fetch(32'h1060, M_STALL);

        // inv_all during REQ: fill lands invalid, so the same word is requested again.
        addr_q.push_back(32'h1050);
        addr_q.push_back(32'h1050);
        expect_inst(32'h0C80_0693, 1'b1);
        do_fetch(32'h1050, M_INV);

        // Everything was invalidated, so the first line misses again.
        addr_q.push_back(32'h1000);
        expect_inst(32'h00A0_0093, 1'b1);
        do_fetch(32'h1000, M_NORMAL);

        repeat (2) @(posedge clk_in);
        #1;
        end_chk = 1'b1;
        for (int c = 0; c < 10 && !end_done; c++)
            @(posedge clk_in);
        if (!end_done) begin
            $display("FAIL end_check: monitor did not run, got 0, want 1");
            $fatal(1, "end check not reached");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
